// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: WIDTH-bit add/subtract with the carry registered between SEG-bit segments.
// Stage k resolves sum segment k. One global stall freezes every stage under back-pressure.
module seg_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);
   localparam int NSTAGE = WIDTH / SEG;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   always_comb begin
      adv     = !out_valid || out_ready;
      b_eff   = sub ? ~b : b;
      cin_eff = sub ? 1'b1 : ci;
   end

   assign in_ready = adv;

   for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
      // Segments still waiting to be resolved after this stage.
      localparam int REM = NSTAGE - 1 - gi;

      logic [(REM+1)*SEG-1:0] src_a;
      logic [(REM+1)*SEG-1:0] src_b;
      logic                   src_v;
      logic                   src_c;
      logic [SEG:0]           seg_res;
      logic                   valid_q;
      logic                   valid_d;
      logic                   carry_q;
      logic                   carry_d;
      logic [(gi+1)*SEG-1:0]  sum_q;
      logic [(gi+1)*SEG-1:0]  sum_d;

      if (gi == 0) begin : g_head
         always_comb begin
            src_a = a;
            src_b = b_eff;
            src_v = in_valid;
            src_c = cin_eff;
         end
         always_comb begin
            sum_d = adv ? seg_res[SEG-1:0] : sum_q;
         end
      end else begin : g_body
         always_comb begin
            src_a = g_stage[gi-1].g_ops.opa_q;
            src_b = g_stage[gi-1].g_ops.opb_q;
            src_v = g_stage[gi-1].valid_q;
            src_c = g_stage[gi-1].carry_q;
         end
         always_comb begin
            sum_d = adv ? {seg_res[SEG-1:0], g_stage[gi-1].sum_q} : sum_q;
         end
      end

      always_comb begin
         seg_res = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]} + {{SEG{1'b0}}, src_c};
         valid_d = adv ? src_v : valid_q;
         carry_d = adv ? seg_res[SEG] : carry_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
         end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
         end
      end

      if (REM > 0) begin : g_ops
         // Skewed operand segments, carried forward until their stage resolves them.
         logic [REM*SEG-1:0] opa_q;
         logic [REM*SEG-1:0] opa_d;
         logic [REM*SEG-1:0] opb_q;
         logic [REM*SEG-1:0] opb_d;

         always_comb begin
            opa_d = adv ? src_a[(REM+1)*SEG-1:SEG] : opa_q;
            opb_d = adv ? src_b[(REM+1)*SEG-1:SEG] : opb_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               opa_q <= '0;
               opb_q <= '0;
            end else begin
               opa_q <= opa_d;
               opb_q <= opob_sel(opb_d);
            end
         end

         function automatic logic [REM*SEG-1:0] opob_sel(input logic [REM*SEG-1:0] v);
            return v;
         endfunction
      end else begin : g_tail
         // Carry into the MSB is recovered as a ^ b ^ sum at the MSB position.
         logic ovf_q;
         logic ovf_d;

         always_comb begin
            ovf_d = adv ? (src_a[SEG-1] ^ src_b[SEG-1] ^ seg_res[SEG-1] ^ seg_res[SEG]) : ovf_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign out_valid = g_stage[NSTAGE-1].valid_q;
   assign sum       = g_stage[NSTAGE-1].sum_q;
   assign co        = g_stage[NSTAGE-1].carry_q;
   assign ovf       = g_stage[NSTAGE-1].g_tail.ovf_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Scoreboard bench for seg_pipe_adder: three instances (16/4, 4/4, 8/1) checked against
// an integer-arithmetic reference model with queues of expected results.
module tb_seg_pipe_adder;
   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        v;
   } res_t;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, ci, sub, out_valid, co, ovf;
   logic        out_ready = 1'b1;
   logic [15:0] a, b, sum;

   logic        iv4, ir4, ci4, sub4, ov4, co4, vf4;
   logic [3:0]  a4, b4, s4;
   logic        iv8, ir8, ci8, sub8, ov8, co8, vf8;
   logic [7:0]  a8, b8, s8;
   logic        rdy_small = 1'b1;

   int   total = 0;
   int   bad   = 0;
   int   mode  = 1;
   int   n_in  = 0;
   int   n_out = 0;
   res_t exp_q[$];
   res_t q4[$];
   res_t q8[$];

   seg_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
   );
   seg_pipe_adder #(.WIDTH(4), .SEG(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .ci(ci4), .sub(sub4), .out_valid(ov4), .out_ready(rdy_small), .sum(s4), .co(co4), .ovf(vf4)
   );
   seg_pipe_adder #(.WIDTH(8), .SEG(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .ci(ci8), .sub(sub8), .out_valid(ov8), .out_ready(rdy_small), .sum(s8), .co(co8), .ovf(vf8)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
   function automatic res_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                  input logic c, input logic s);
      longint m, ux, uy, sx, sy, ur, sr;
      res_t   r;
      m  = longint'(1) << w;
      ux = longint'(x);
      uy = longint'(y);
      sx = (ux >= m / 2) ? ux - m : ux;
      sy = (uy >= m / 2) ? uy - m : uy;
      if (s) begin
         ur  = ux - uy;
         sr  = sx - sy;
         r.c = (ux >= uy);
      end else begin
         ur  = ux + uy + longint'(c);
         sr  = sx + sy + longint'(c);
         r.c = (ur >= m);
      end
      if (ur < 0) ur = ur + m;
      ur  = ur % m;
      r.s = 16'(ur);
      r.v = (sr >= m / 2) || (sr < -(m / 2));
      return r;
   endfunction

   // out_ready driver: 0 = hold, 1 = always ready, 2 = random.
   initial forever begin
      @(posedge clk);
      #2;
      case (mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor for the 16-bit instance: pops on every output transfer, checks stall stability.
   initial begin
      res_t mr;
      res_t held;
      logic held_v;
      held_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (held_v) begin
               chk("stable_sum", 32'(sum), 32'(held.s));
               chk("stable_co", 32'(co), 32'(held.c));
               chk("stable_ovf", 32'(ovf), 32'(held.v));
            end
            if (out_ready) begin
               held_v = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", 32'(sum), 32'hdeadbeef);
               end else begin
                  mr = exp_q.pop_front();
                  n_out++;
                  $display("xfer16 %0d: sum=%h co=%b ovf=%b", n_out, sum, co, ovf);
                  chk("sum", 32'(sum), 32'(mr.s));
                  chk("co", 32'(co), 32'(mr.c));
                  chk("ovf", 32'(ovf), 32'(mr.v));
               end
            end else begin
               held.s = sum;
               held.c = co;
               held.v = ovf;
               held_v = 1'b1;
            end
         end else begin
            held_v = 1'b0;
         end
      end
   end

   // Monitor for the two small instances (always ready downstream).
   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         if (rst_n && ov4) begin
            if (q4.size() == 0) chk("unexpected_out4", 32'(s4), 32'hdeadbeef);
            else begin
               r = q4.pop_front();
               $display("xfer4: sum=%h co=%b ovf=%b", s4, co4, vf4);
               chk("sum4", 32'(s4), 32'(r.s[3:0]));
               chk("co4", 32'(co4), 32'(r.c));
               chk("ovf4", 32'(vf4), 32'(r.v));
            end
         end
         if (rst_n && ov8) begin
            if (q8.size() == 0) chk("unexpected_out8", 32'(s8), 32'hdeadbeef);
            else begin
               r = q8.pop_front();
               $display("xfer8: sum=%h co=%b ovf=%b", s8, co8, vf8);
               chk("sum8", 32'(s8), 32'(r.s[7:0]));
               chk("co8", 32'(co8), 32'(r.c));
               chk("ovf8", 32'(vf8), 32'(r.v));
            end
         end
      end
   end

   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
      int waitc;
      waitc = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = x;
      b = y;
      ci = c;
      sub = s;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waitc++;
         if (waitc > 200) break;
      end
      if (waitc > 200) chk("issue_timeout", 32'(waitc), 32'd0);
      else begin
         exp_q.push_back(model(16, x, y, c, s));
         n_in++;
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts negedges until out_valid is seen (bounded).
   task automatic wait_lat(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      chk("count_in_out", 32'(n_out), 32'(n_in));
   endtask

   initial begin
      int lat;
      int cnt;
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      iv4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; sub4 = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_ov4", 32'(ov4), 32'd0);
      chk("rst_ov8", 32'(ov8), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // All-ones + 1 wraps, latency NSTAGE, single-cycle valid.
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      idle();
      wait_lat(lat);
      chk("lat_wrap", 32'(lat), 32'd4);
      chk("wrap_sum", 32'(sum), 32'h0000);
      chk("wrap_co", 32'(co), 32'd1);
      chk("wrap_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      chk("valid_one_cycle", 32'(out_valid), 32'd0);

      // Signed overflow on add and on subtract.
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h8000, 16'h0001, 1'b0, 1'b1);
      idle();
      wait_lat(lat);
      chk("ovf_add_sum", 32'(sum), 32'h8000);
      chk("ovf_add_flag", 32'(ovf), 32'd1);
      @(negedge clk);
      chk("ovf_sub_sum", 32'(sum), 32'h7FFF);
      chk("ovf_sub_co", 32'(co), 32'd1);
      chk("ovf_sub_flag", 32'(ovf), 32'd1);
      wait_drain();

      // Random stream with random back-pressure.
      mode = 2;
      cnt = 0;
      while (cnt < 64) begin
         if ($urandom_range(0, 3) != 0) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            cnt++;
         end else begin
            idle();
         end
      end
      idle();
      mode = 1;
      wait_drain();

      // Fill the pipe under back-pressure, then release.
      mode = 0;
      idle();
      for (int i = 0; i < 4; i++) issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      idle();
      wait_lat(lat);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1 mode = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("release_consecutive", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      chk("release_empty", 32'(out_valid), 32'd0);
      wait_drain();

      // Reset pulse with transactions in flight.
      mode = 0;
      idle();
      for (int i = 0; i < 3; i++) issue(16'($urandom), 16'($urandom), 1'b0, 1'b0);
      idle();
      wait_lat(lat);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_sum", 32'(sum), 32'd0);
      n_in = n_in - exp_q.size();
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      mode = 1;
      repeat (8) begin
         @(negedge clk);
         chk("no_stale", 32'(out_valid), 32'd0);
      end
      issue(16'h1234, 16'h1111, 1'b0, 1'b0);
      idle();
      wait_lat(lat);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_sum", 32'(sum), 32'h2345);
      wait_drain();

      // WIDTH=4, SEG=4: single-stage, latency 1.
      @(posedge clk);
      #1 iv4 = 1'b1; a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1; sub4 = 1'b0;
      @(negedge clk);
      chk("ir4", 32'(ir4), 32'd1);
      q4.push_back(model(4, 16'h000F, 16'h0000, 1'b1, 1'b0));
      @(posedge clk);
      #1 iv4 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ov4 && lat < 50);
      chk("lat4", 32'(lat), 32'd1);
      chk("w4_sum", 32'(s4), 32'h0);
      chk("w4_co", 32'(co4), 32'd1);

      // WIDTH=8, SEG=1: carry crosses every bit boundary, latency 8.
      @(posedge clk);
      #1 iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0;
      @(negedge clk);
      chk("ir8", 32'(ir8), 32'd1);
      q8.push_back(model(8, 16'h00FF, 16'h0001, 1'b0, 1'b0));
      @(posedge clk);
      #1 iv8 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ov8 && lat < 50);
      chk("lat8", 32'(lat), 32'd8);
      chk("w8_sum", 32'(s8), 32'h00);
      chk("w8_co", 32'(co8), 32'd1);

      // Back-to-back random streams into both small instances.
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); sub4 = 1'($urandom);
         iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
         @(negedge clk);
         q4.push_back(model(4, 16'(a4), 16'(b4), ci4, sub4));
         q8.push_back(model(8, 16'(a8), 16'(b8), ci8, sub8));
      end
      @(posedge clk);
      #1 iv4 = 1'b0; iv8 = 1'b0;
      cnt = 0;
      while ((q4.size() != 0 || q8.size() != 0) && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("small_drain", 32'(q4.size() + q8.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
